// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES request arbiter.
//   AES_BLK_W   : width of one AES block / IV / result
//   AES_MODE_W  : width of the core mode field
//   arb_state_e : arbiter sequencing states (IDLE -> START -> WAIT -> RESP)
package aes_arb_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_MODE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin priority picker.
// Ports:
//   valid     in  NUM_REQ  request vector
//   rr_ptr    in  ID_W     highest-priority index (must be < NUM_REQ)
//   grant     out NUM_REQ  one-hot grant (all zero when nothing is valid)
//   winner    out ID_W     index of the granted requester (0 when none)
//   any_valid out 1        at least one request is valid
module aes_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  always_comb begin
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    // Visit offsets from farthest to nearest; the last hit is the first valid
    // requester at or after rr_ptr (with wrap-around).
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (valid[i] && (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
          grant     = '0;
          grant[i]  = 1'b1;
          winner    = ID_W'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between NUM_REQ requesters. Jobs are accepted
// round-robin over valid/ready, the winner's operands are latched onto the
// core inputs, start is pulsed, and the core result is returned on the
// winner's response channel.
//
// Optional build macro AES_ARB_TIMEOUT_EN: adds a WAIT-state watchdog that
// returns rsp_err = 1 / rsp_data = 0 after TIMEOUT_CYCLES - 1 WAIT cycles.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester job handshake
//   req_enc_dec/mode/data/iv    per-requester job operands (packed by index)
//   rsp_valid/rsp_ready         per-requester response handshake
//   rsp_data, rsp_err           shared response payload
//   aes_start ... aes_iv        latched operands and start pulse to the core
//   aes_result, aes_done        core result and completion pulse
//   busy, grant_id              status: not idle / current or last winner
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_enc_dec,
  input  logic [AES_MODE_W*NUM_REQ-1:0]   req_mode,
  input  logic [AES_BLK_W*NUM_REQ-1:0]    req_data,
  input  logic [AES_BLK_W*NUM_REQ-1:0]    req_iv,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [AES_BLK_W-1:0]            rsp_data,
  output logic                            rsp_err,
  output logic                            aes_start,
  output logic                            aes_enc_dec,
  output logic [AES_MODE_W-1:0]           aes_mode,
  output logic [AES_BLK_W-1:0]            aes_plaintext,
  output logic [AES_BLK_W-1:0]            aes_iv,
  input  logic [AES_BLK_W-1:0]            aes_result,
  input  logic                            aes_done,
  output logic                            busy,
  output logic [ID_W-1:0]                 grant_id
);

  if ((1 << ID_W) < NUM_REQ || NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("aes_req_arbiter: NUM_REQ must be 1..8 and fit in ID_W bits");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("aes_req_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic                   enc_dec_q, enc_dec_d;
  logic [AES_MODE_W-1:0]  mode_q, mode_d;
  logic [AES_BLK_W-1:0]   pt_q, pt_d;
  logic [AES_BLK_W-1:0]   iv_q, iv_d;
  logic [AES_BLK_W-1:0]   rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [ID_W-1:0]        pick_winner;
  logic                   pick_any;

  logic                   sel_enc_dec;
  logic [AES_MODE_W-1:0]  sel_mode;
  logic [AES_BLK_W-1:0]   sel_data;
  logic [AES_BLK_W-1:0]   sel_iv;
  logic                   rsp_taken;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rsp_err_q, rsp_err_d;
`endif

  aes_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .winner    (pick_winner),
    .any_valid (pick_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_enc_dec = 1'b0;
    sel_mode    = '0;
    sel_data    = '0;
    sel_iv      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_enc_dec = req_enc_dec[i];
        sel_mode    = req_mode[i*AES_MODE_W +: AES_MODE_W];
        sel_data    = req_data[i*AES_BLK_W +: AES_BLK_W];
        sel_iv      = req_iv[i*AES_BLK_W +: AES_BLK_W];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && (grant_id_q == ID_W'(i));
    end
  end

  // Only the granted requester's rsp_ready bit can complete a response.
  assign rsp_taken = |(rsp_valid & rsp_ready);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    enc_dec_d  = enc_dec_q;
    mode_d     = mode_q;
    pt_d       = pt_q;
    iv_d       = iv_q;
    rsp_data_d = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = START;
          grant_id_d = pick_winner;
          enc_dec_d  = sel_enc_dec;
          mode_d     = sel_mode;
          pt_d       = sel_data;
          iv_d       = sel_iv;
          rr_ptr_d   = (int'(pick_winner) + 1 >= NUM_REQ) ? '0 : pick_winner + 1'b1;
        end
      end
      START: begin
        // A done pulse here cannot belong to this job and is ignored.
        state_d = WAIT;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (aes_done) begin
          state_d    = RESP;
          rsp_data_d = aes_result;
`ifdef AES_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d    = RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
`endif
        end
      end
      RESP: begin
        if (rsp_taken) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      enc_dec_q  <= 1'b0;
      mode_q     <= '0;
      pt_q       <= '0;
      iv_q       <= '0;
      rsp_data_q <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      enc_dec_q  <= enc_dec_d;
      mode_q     <= mode_d;
      pt_q       <= pt_d;
      iv_q       <= iv_d;
      rsp_data_q <= rsp_data_d;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  assign req_ready     = (state_q == IDLE) ? pick_grant : '0;
  assign aes_start     = (state_q == START);
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_id_q;
  assign aes_enc_dec   = enc_dec_q;
  assign aes_mode      = mode_q;
  assign aes_plaintext = pt_q;
  assign aes_iv        = iv_q;
  assign rsp_data      = rsp_data_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign rsp_err       = rsp_err_q;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Scoreboard bench for aes_req_arbiter with a behavioural AES core stub.
module tb_aes_req_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int ID_W           = 3;
  localparam int TIMEOUT_CYCLES = 16;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_enc_dec;
  logic [3*NUM_REQ-1:0]     req_mode;
  logic [128*NUM_REQ-1:0]   req_data;
  logic [128*NUM_REQ-1:0]   req_iv;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [127:0]             rsp_data;
  logic                     rsp_err;
  logic                     aes_start;
  logic                     aes_enc_dec;
  logic [2:0]               aes_mode;
  logic [127:0]             aes_plaintext;
  logic [127:0]             aes_iv;
  logic [127:0]             aes_result;
  logic                     aes_done;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;

  aes_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_enc_dec   (req_enc_dec),
    .req_mode      (req_mode),
    .req_data      (req_data),
    .req_iv        (req_iv),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .aes_start     (aes_start),
    .aes_enc_dec   (aes_enc_dec),
    .aes_mode      (aes_mode),
    .aes_plaintext (aes_plaintext),
    .aes_iv        (aes_iv),
    .aes_result    (aes_result),
    .aes_done      (aes_done),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic         ed;
    logic [2:0]   mode;
    logic [127:0] data;
    logic [127:0] iv;
  } job_t;

  typedef struct {
    int           id;
    logic [127:0] data;
    logic         err;
  } exp_t;

  job_t jobq[$];
  exp_t sb[$];
  int   hs_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [NUM_REQ-1:0] hs_prev;
  logic [NUM_REQ-1:0] rsp_ready_mask;
  logic [NUM_REQ-1:0] prev_rsp;
  bit   manual, core_hang, spur_idle, spur_at_start, any_rsp_seen;
  int   core_lat, done_cnt, model_rr, last_winner;
  int   start_cyc, done_cyc, hs_cyc, rsp_cyc, n_starts;
  logic [127:0] pending;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Core stub: the FIPS-197 example block maps to its known ciphertext,
  // anything else to a cheap mix of all operands.
  function automatic logic [127:0] core_fn(input logic ed, input logic [2:0] m,
                                           input logic [127:0] p, input logic [127:0] iv);
    if (ed && m == 3'd0 && p == 128'h00112233445566778899aabbccddeeff)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    return (p ^ {iv[63:0], iv[127:64]}) + {124'd0, ed, m};
  endfunction

  task automatic push_job(input int id, input logic ed, input logic [2:0] m,
                          input logic [127:0] d, input logic [127:0] iv);
    job_t j;
    j.id = id; j.ed = ed; j.mode = m; j.data = d; j.iv = iv;
    jobq.push_back(j);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Requester drivers, core stub and monitor/scoreboard, all stepped on negedge.
  initial begin : bfm
    int idx, w;
    logic [NUM_REQ-1:0] hs, exp_rdy;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!manual && (hs_prev[i] || !req_valid[i])) begin
          idx = -1;
          for (int k = 0; k < jobq.size(); k++)
            if (idx < 0 && jobq[k].id == i) idx = k;
          if (idx >= 0) begin
            req_valid[i]           = 1'b1;
            req_enc_dec[i]         = jobq[idx].ed;
            req_mode[i*3 +: 3]     = jobq[idx].mode;
            req_data[i*128 +: 128] = jobq[idx].data;
            req_iv[i*128 +: 128]   = jobq[idx].iv;
            jobq.delete(idx);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      hs_prev   = '0;
      rsp_ready = rsp_ready_mask;

      aes_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          aes_done   = 1'b1;
          aes_result = pending;
          done_cyc   = cyc;
        end
      end
      if (spur_idle) begin
        aes_done   = 1'b1;
        aes_result = '1;
        spur_idle  = 1'b0;
      end
      if (aes_start) begin
        if (!core_hang) begin
          pending  = core_fn(aes_enc_dec, aes_mode, aes_plaintext, aes_iv);
          done_cnt = core_lat;
        end
        if (spur_at_start) begin
          aes_done      = 1'b1;
          aes_result    = ~pending;
          spur_at_start = 1'b0;
        end
      end

      #2;
      if (!resetn) begin
        sb.delete();
        model_rr = 0;
        hs_prev  = '0;
        prev_rsp = '0;
      end else begin
        hs = req_valid & req_ready;
        if (hs != '0) begin
          w = -1;
          for (int k = 0; k < NUM_REQ; k++)
            if (w < 0 && req_valid[(model_rr + k) % NUM_REQ]) w = (model_rr + k) % NUM_REQ;
          exp_rdy    = '0;
          exp_rdy[w] = 1'b1;
          check_eq("req_ready_onehot", req_ready, exp_rdy);
          e.id = w;
          if (core_hang) begin
            e.data = '0;
            e.err  = 1'b1;
          end else begin
            e.data = core_fn(req_enc_dec[w], req_mode[w*3 +: 3], req_data[w*128 +: 128],
                             req_iv[w*128 +: 128]);
            e.err  = 1'b0;
          end
          sb.push_back(e);
          hs_log.push_back(w);
          last_winner = w;
          model_rr    = (w + 1) % NUM_REQ;
          hs_prev     = hs;
          hs_cyc      = cyc;
        end
        if (aes_start) begin
          n_starts++;
          start_cyc = cyc;
          check_eq("grant_id", grant_id, last_winner);
        end
        if (rsp_valid != '0) begin
          any_rsp_seen = 1'b1;
          if (prev_rsp == '0) rsp_cyc = cyc;
        end
        prev_rsp = rsp_valid;
        if (|(rsp_valid & rsp_ready)) begin
          if (sb.size() == 0) begin
            check_eq("rsp_unexpected", rsp_valid, '0);
          end else begin
            e = sb.pop_front();
            exp_rdy       = '0;
            exp_rdy[e.id] = 1'b1;
            check_eq("rsp_id", rsp_valid, exp_rdy);
            check_eq("rsp_data", rsp_data, e.data);
            check_eq("rsp_err", rsp_err, e.err);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req_ready"}, req_ready, '0);
    check_eq({pfx, "_rsp_valid"}, rsp_valid, '0);
    check_eq({pfx, "_rsp_data"}, rsp_data, '0);
    check_eq({pfx, "_rsp_err"}, rsp_err, '0);
    check_eq({pfx, "_aes_start"}, aes_start, '0);
    check_eq({pfx, "_aes_enc_dec"}, aes_enc_dec, '0);
    check_eq({pfx, "_aes_mode"}, aes_mode, '0);
    check_eq({pfx, "_aes_pt"}, aes_plaintext, '0);
    check_eq({pfx, "_aes_iv"}, aes_iv, '0);
    check_eq({pfx, "_busy"}, busy, '0);
    check_eq({pfx, "_grant_id"}, grant_id, '0);
  endtask

  task automatic apply_reset(input int n, input string pfx);
    @(negedge clk);
    resetn = 1'b0;
    jobq.delete();
    repeat (n) @(negedge clk);
    #3;
    check_reset_outputs(pfx);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && jobq.size() == 0 && req_valid == '0 && !busy) ok = 1'b1;
    end
    check_eq("drain_timeout", ok, 1'b1);
  endtask

  task automatic wait_start(input int st0, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      #3;
      if (n_starts > st0) ok = 1'b1;
    end
    check_eq("start_timeout", ok, 1'b1);
  endtask

  initial begin : main
    int st0;
    logic [127:0] d1, iv1;
    resetn = 1'b0;
    req_valid = '0; req_enc_dec = '0; req_mode = '0; req_data = '0; req_iv = '0;
    rsp_ready = '0; rsp_ready_mask = '1; aes_result = '0; aes_done = 1'b0;
    hs_prev = '0; prev_rsp = '0;
    manual = 0; core_hang = 0; spur_idle = 0; spur_at_start = 0; any_rsp_seen = 0;
    core_lat = 12; done_cnt = 0; model_rr = 0; last_winner = 0; n_starts = 0;
    start_cyc = 0; done_cyc = 0; hs_cyc = 0; rsp_cyc = 0; pending = '0;

    apply_reset(2, "rst");

    // Single ECB job with the known FIPS-197 block, 12-cycle core.
    push_job(0, 1'b1, 3'd0, 128'h00112233445566778899aabbccddeeff, '0);
    wait_drain(200);
    check_eq("t1_start_lat", start_cyc - hs_cyc, 1);
    check_eq("t1_core_lat", done_cyc - start_cyc, 12);
    check_eq("t1_rsp_lat", rsp_cyc - done_cyc, 1);

    // Contention: both requesters keep a job pending; grants alternate from 0.
    apply_reset(1, "rst2");
    hs_log.delete();
    core_lat = 3;
    for (int k = 0; k < 4; k++) begin
      push_job(0, k[0], 3'(k), rnd128(), rnd128());
      push_job(1, ~k[0], 3'(k + 4), rnd128(), rnd128());
    end
    wait_drain(1000);
    check_eq("t2_grant_count", hs_log.size(), 8);
    for (int k = 0; k < hs_log.size(); k++)
      check_eq($sformatf("t2_grant%0d", k), hs_log[k], k % 2);

    // Response backpressure on requester 1 while requester 0 offers then withdraws.
    rsp_ready_mask = 2'b01;
    d1  = rnd128();
    iv1 = rnd128();
    push_job(1, 1'b0, 3'd2, d1, iv1);
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        #3;
        if (rsp_valid[1]) ok = 1'b1;
      end
      check_eq("t3_rsp_timeout", ok, 1'b1);
    end
    st0 = n_starts;
    manual = 1'b1;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 3) req_valid[0] = 1'b0;
      #3;
      check_eq("t3_ctl", {rsp_valid, req_ready, aes_start, busy}, 6'b10_00_0_1);
      check_eq("t3_data", rsp_data, core_fn(1'b0, 3'd2, d1, iv1));
    end
    rsp_ready_mask = 2'b11;
    manual = 1'b0;
    wait_drain(100);
    repeat (10) @(negedge clk);
    check_eq("t3_no_start", n_starts - st0, 0);

    // Spurious done in IDLE and during START.
    spur_idle = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    check_eq("t4_idle_busy", busy, 1'b0);
    check_eq("t4_idle_rsp", rsp_valid, '0);
    core_lat = 7;
    spur_at_start = 1'b1;
    push_job(0, 1'b1, 3'd1, rnd128(), rnd128());
    wait_drain(200);
    check_eq("t4_done_lat", done_cyc - start_cyc, 7);
    check_eq("t4_rsp_lat", rsp_cyc - done_cyc, 1);

    // Reset in the middle of WAIT; the late done must be ignored.
    core_lat = 12;
    st0 = n_starts;
    push_job(0, 1'b1, 3'd3, rnd128(), rnd128());
    wait_start(st0, 50);
    repeat (3) @(negedge clk);
    apply_reset(1, "t5_rst");
    any_rsp_seen = 1'b0;
    repeat (15) @(negedge clk);
    #3;
    check_eq("t5_no_rsp", any_rsp_seen, 1'b0);
    check_eq("t5_idle", busy, 1'b0);
    hs_log.delete();
    core_lat = 2;
    push_job(1, 1'b0, 3'd4, rnd128(), rnd128());
    push_job(0, 1'b1, 3'd5, rnd128(), rnd128());
    wait_drain(200);
    check_eq("t5_grant_count", hs_log.size(), 2);
    if (hs_log.size() > 0) check_eq("t5_first_grant", hs_log[0], 0);

`ifdef AES_ARB_TIMEOUT_EN
    // Core never completes: watchdog returns an error response.
    core_hang = 1'b1;
    push_job(1, 1'b1, 3'd0, rnd128(), rnd128());
    wait_drain(200);
    check_eq("t6_timeout_lat", rsp_cyc - start_cyc, TIMEOUT_CYCLES);
    core_hang = 1'b0;
`endif

    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
